// File: rtl/scroll_sequencer.sv
// scroll_sequencer: steps a 4-bit frame index for the seven-segment scroll display.
// Ports: CLK, RST_N (sync active-low), RUN, DIR, LOOP, STEP, CLR in; FRAME[3:0], TICK, BUSY, DONE out.
module scroll_sequencer #(
  parameter int unsigned DIV        = 12_500_000,
  parameter int unsigned LAST_FRAME = 9
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RUN,
  input  logic       DIR,
  input  logic       LOOP,
  input  logic       STEP,
  input  logic       CLR,
  output logic [3:0] FRAME,
  output logic       TICK,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned   PW     = $clog2(DIV);
  localparam logic [PW-1:0] CNT_TC = PW'(DIV - 1);
  localparam logic [3:0]    LAST   = 4'(LAST_FRAME);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_cnt_nxt;
  logic [3:0]    r_frame;
  logic [3:0]    w_frame_nxt;
  logic          r_tick;
  logic          w_tick_nxt;
  logic          r_step_q;
  logic          w_step_rise;
  logic          w_tc;
  logic [3:0]    w_adv_frame;
  logic          w_adv_end;

  assign w_step_rise = STEP & ~r_step_q;
  assign w_tc        = (r_cnt == CNT_TC);

  // Candidate next frame, already wrapped; w_adv_end marks
  // that the wrap crossed the end of the sequence.
  always_comb begin
    w_adv_frame = r_frame;
    w_adv_end   = 1'b0;
    if (!DIR) begin
      if (r_frame < LAST) begin
        w_adv_frame = r_frame + 4'd1;
      end else begin
        w_adv_frame = 4'd0;
        w_adv_end   = 1'b1;
      end
    end else begin
      if (r_frame > LAST) begin
        w_adv_frame = LAST;
      end else if (r_frame != 4'd0) begin
        w_adv_frame = r_frame - 4'd1;
      end else begin
        w_adv_frame = LAST;
        w_adv_end   = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_frame_nxt = r_frame;
    w_tick_nxt  = 1'b0;
    if (CLR) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_frame_nxt = DIR ? LAST : 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          // Manual steps always wrap, whatever LOOP says.
          if (w_step_rise) begin
            w_frame_nxt = w_adv_frame;
            w_tick_nxt  = 1'b1;
          end
          if (RUN) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_tc) begin
            w_cnt_nxt = '0;
            if (w_adv_end && !LOOP) begin
              w_state_nxt = S_DONE;
            end else begin
              w_frame_nxt = w_adv_frame;
              w_tick_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + PW'(1);
          end
          // A terminal-count advance still lands before pausing.
          if (!RUN) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        S_DONE: begin
          w_cnt_nxt = '0;
          if (!RUN) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_frame  <= 4'd0;
      r_tick   <= 1'b0;
      r_step_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_frame  <= w_frame_nxt;
      r_tick   <= w_tick_nxt;
      r_step_q <= STEP;
    end
  end

  assign FRAME = r_frame;
  assign TICK  = r_tick;
  assign BUSY  = (r_state == S_RUN);
  assign DONE  = (r_state == S_DONE);

endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: directed and randomized checks of scroll_sequencer
// against a frame-level reference model.
module tb_scroll_sequencer;

  localparam int MD = 4;
  localparam int ML = 9;

  logic       CLK = 1'b0;
  logic       RST_N, RUN, DIR, LOOP, STEP, CLR;
  logic [3:0] FRAME, FRAME2;
  logic       TICK, BUSY, DONE, TICK2, BUSY2, DONE2;

  always #5 CLK = ~CLK;

  scroll_sequencer #(.DIV(MD), .LAST_FRAME(ML)) dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .DIR(DIR),
    .LOOP(LOOP), .STEP(STEP), .CLR(CLR),
    .FRAME(FRAME), .TICK(TICK), .BUSY(BUSY), .DONE(DONE)
  );

  scroll_sequencer #(.DIV(2), .LAST_FRAME(15)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .DIR(DIR),
    .LOOP(LOOP), .STEP(STEP), .CLR(CLR),
    .FRAME(FRAME2), .TICK(TICK2), .BUSY(BUSY2), .DONE(DONE2)
  );

  int checks = 0;
  int failures = 0;

  // Reference model of dut: frame number, running/finished
  // flags and cycles elapsed in the current frame period.
  int m_frame = 0;
  bit m_tick = 0, m_busy = 0, m_done = 0, m_stepq = 0;
  int m_cnt = 0;

  // -1 = sequence end reached
  function automatic int adv(int f, bit dir, int last);
    if (!dir) return (f < last) ? f + 1 : -1;
    if (f > last) return last;
    return (f > 0) ? f - 1 : -1;
  endfunction

  task automatic model_edge();
    bit rise;
    int n;
    rise = STEP && !m_stepq;
    m_stepq = STEP;
    if (!RST_N) begin
      m_frame = 0; m_tick = 0; m_busy = 0;
      m_done = 0; m_cnt = 0; m_stepq = 0;
      return;
    end
    if (CLR) begin
      m_busy = 0; m_done = 0; m_cnt = 0; m_tick = 0;
      m_frame = DIR ? ML : 0;
      return;
    end
    m_tick = 0;
    if (m_busy) begin
      if (m_cnt == MD - 1) begin
        m_cnt = 0;
        n = adv(m_frame, DIR, ML);
        if (n < 0 && !LOOP) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_frame = (n >= 0) ? n : (DIR ? ML : 0);
          m_tick = 1;
        end
      end else begin
        m_cnt++;
      end
      if (!RUN) begin
        m_busy = 0; m_done = 0; m_cnt = 0;
      end
    end else if (m_done) begin
      if (!RUN) m_done = 0;
    end else begin
      if (rise) begin
        n = adv(m_frame, DIR, ML);
        m_frame = (n >= 0) ? n : (DIR ? ML : 0);
        m_tick = 1;
      end
      if (RUN) begin
        m_busy = 1; m_cnt = 0;
      end
    end
  endtask

  // One clock: model sees pre-edge inputs; outputs sampled 1ns after.
  task automatic cyc();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 0; RUN = 0; DIR = 0; LOOP = 1; STEP = 0; CLR = 0;
    cyc(); cyc();
    checks++;
    if ({FRAME, TICK, BUSY, DONE} !== 7'd0) begin
      failures++;
      $display("FAIL reset got=%b exp=0000000", {FRAME, TICK, BUSY, DONE});
    end
    checks++;
    if ({FRAME2, TICK2, BUSY2, DONE2} !== 7'd0) begin
      failures++;
      $display("FAIL reset2 got=%b exp=0000000", {FRAME2, TICK2, BUSY2, DONE2});
    end
  endtask

  task automatic test_forward_loop();
    int ef;
    bit et;
    RST_N = 1; RUN = 1; DIR = 0; LOOP = 1;
    cyc();
    checks++;
    if (BUSY !== 1'b1 || FRAME !== 4'd0) begin
      failures++;
      $display("FAIL fwd_start busy=%b frame=%0d exp busy=1 frame=0", BUSY, FRAME);
    end
    for (int k = 1; k <= 44; k++) begin
      cyc();
      ef = (k / MD) % (ML + 1);
      et = (k % MD) == 0;
      checks++;
      if (FRAME !== 4'(ef) || TICK !== et || BUSY !== 1'b1) begin
        failures++;
        $display("FAIL fwd_loop k=%0d frame=%0d tick=%b busy=%b exp frame=%0d tick=%b busy=1",
                 k, FRAME, TICK, BUSY, ef, et);
      end
    end
  endtask

  task automatic test_oneshot_reverse();
    int ef;
    RUN = 0; cyc();
    DIR = 1; CLR = 1;
    cyc();
    checks++;
    if (FRAME !== 4'd9 || BUSY !== 1'b0 || TICK !== 1'b0) begin
      failures++;
      $display("FAIL clr_rev frame=%0d busy=%b tick=%b exp 9 0 0", FRAME, BUSY, TICK);
    end
    CLR = 0; RUN = 1; LOOP = 0;
    cyc();
    for (int k = 1; k <= 44; k++) begin
      cyc();
      if (k < 40) begin
        ef = 9 - k / MD;
        checks++;
        if (FRAME !== 4'(ef) || TICK !== ((k % MD) == 0) || BUSY !== 1'b1 || DONE !== 1'b0) begin
          failures++;
          $display("FAIL oneshot_rev k=%0d frame=%0d tick=%b busy=%b done=%b exp frame=%0d",
                   k, FRAME, TICK, BUSY, DONE, ef);
        end
      end else begin
        checks++;
        if (FRAME !== 4'd0 || TICK !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b1) begin
          failures++;
          $display("FAIL oneshot_done k=%0d frame=%0d tick=%b busy=%b done=%b exp 0 0 0 1",
                   k, FRAME, TICK, BUSY, DONE);
        end
      end
    end
    RUN = 0;
    cyc();
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || FRAME !== 4'd0) begin
      failures++;
      $display("FAIL done_exit done=%b busy=%b frame=%0d exp 0 0 0", DONE, BUSY, FRAME);
    end
  endtask

  task automatic test_pause_resume();
    DIR = 0; LOOP = 1; RUN = 1;
    cyc();
    for (int k = 1; k <= 4; k++) cyc();
    checks++;
    if (FRAME !== 4'd1 || TICK !== 1'b1) begin
      failures++;
      $display("FAIL pause_adv frame=%0d tick=%b exp 1 1", FRAME, TICK);
    end
    cyc();
    RUN = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if (FRAME !== 4'd1 || TICK !== 1'b0 || BUSY !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold k=%0d frame=%0d tick=%b busy=%b exp 1 0 0",
                 k, FRAME, TICK, BUSY);
      end
    end
    RUN = 1;
    cyc();
    for (int j = 1; j <= MD; j++) begin
      cyc();
      checks++;
      if (FRAME !== ((j == MD) ? 4'd2 : 4'd1) || TICK !== (j == MD) || BUSY !== 1'b1) begin
        failures++;
        $display("FAIL resume j=%0d frame=%0d tick=%b busy=%b exp frame=%0d",
                 j, FRAME, TICK, BUSY, (j == MD) ? 2 : 1);
      end
    end
  endtask

  task automatic test_step_idle();
    int nt;
    RUN = 0; cyc();
    DIR = 1; CLR = 1; cyc();
    CLR = 0; DIR = 0; LOOP = 0; STEP = 1;
    nt = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      nt += TICK;
      checks++;
      if (FRAME !== 4'd0 || BUSY !== 1'b0) begin
        failures++;
        $display("FAIL step_hold k=%0d frame=%0d busy=%b exp 0 0", k, FRAME, BUSY);
      end
    end
    checks++;
    if (nt !== 1) begin
      failures++;
      $display("FAIL step_ticks got=%0d exp=1", nt);
    end
    STEP = 0; cyc();
    RUN = 1; cyc();
    for (int k = 1; k <= MD; k++) begin
      STEP = (k % 2 == 1);
      cyc();
      checks++;
      if (FRAME !== ((k == MD) ? 4'd1 : 4'd0)) begin
        failures++;
        $display("FAIL step_in_run k=%0d frame=%0d exp=%0d", k, FRAME, (k == MD) ? 1 : 0);
      end
    end
    STEP = 0; RUN = 0; cyc();
    STEP = 1; RUN = 1; cyc();
    checks++;
    if (FRAME !== 4'd2 || TICK !== 1'b1 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL step_run_same frame=%0d tick=%b busy=%b exp 2 1 1", FRAME, TICK, BUSY);
    end
    STEP = 0; RUN = 0; cyc();
  endtask

  task automatic test_clr_reset();
    DIR = 0; LOOP = 1; CLR = 1; cyc();
    CLR = 0; RUN = 1; cyc();
    for (int k = 1; k <= 5 * MD; k++) cyc();
    checks++;
    if (FRAME !== 4'd5 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL pre_clr frame=%0d busy=%b exp 5 1", FRAME, BUSY);
    end
    CLR = 1; cyc();
    checks++;
    if (FRAME !== 4'd0 || BUSY !== 1'b0 || TICK !== 1'b0) begin
      failures++;
      $display("FAIL clr_run frame=%0d busy=%b tick=%b exp 0 0 0", FRAME, BUSY, TICK);
    end
    CLR = 0; cyc();
    for (int k = 1; k < 2 * MD; k++) cyc();
    RST_N = 0; STEP = 1; cyc();
    checks++;
    if ({FRAME, TICK, BUSY, DONE} !== 7'd0) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=0000000", {FRAME, TICK, BUSY, DONE});
    end
    RUN = 0; RST_N = 1; cyc();
    checks++;
    if (FRAME !== 4'd1 || TICK !== 1'b1) begin
      failures++;
      $display("FAIL step_thru_reset frame=%0d tick=%b exp 1 1", FRAME, TICK);
    end
    cyc();
    checks++;
    if (FRAME !== 4'd1 || TICK !== 1'b0) begin
      failures++;
      $display("FAIL step_once frame=%0d tick=%b exp 1 0", FRAME, TICK);
    end
    STEP = 0; cyc();
  endtask

  task automatic test_boundary();
    DIR = 0; LOOP = 1; CLR = 1; cyc();
    CLR = 0; RUN = 1; cyc();
    for (int k = 1; k < MD; k++) cyc();
    RUN = 0; cyc();
    checks++;
    if (FRAME !== 4'd1 || TICK !== 1'b1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL tc_runfall frame=%0d tick=%b busy=%b exp 1 1 0", FRAME, TICK, BUSY);
    end
    cyc();
    checks++;
    if (FRAME !== 4'd1 || TICK !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL tc_after frame=%0d tick=%b busy=%b exp 1 0 0", FRAME, TICK, BUSY);
    end
    DIR = 1; CLR = 1; cyc();
    checks++;
    if (FRAME2 !== 4'd15) begin
      failures++;
      $display("FAIL last15_clr got=%0d exp=15", FRAME2);
    end
    CLR = 0; DIR = 0; RUN = 1; cyc();
    cyc(); cyc();
    checks++;
    if (FRAME2 !== 4'd0 || TICK2 !== 1'b1) begin
      failures++;
      $display("FAIL wrap15 frame=%0d tick=%b exp 0 1", FRAME2, TICK2);
    end
    RUN = 0; cyc();
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      RST_N = ($urandom_range(0, 199) != 0);
      CLR   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 11) == 0) RUN  = ~RUN;
      if ($urandom_range(0, 9) == 0)  DIR  = ~DIR;
      if ($urandom_range(0, 9) == 0)  LOOP = ~LOOP;
      STEP = ($urandom_range(0, 2) == 0);
      cyc();
      checks++;
      if (FRAME !== 4'(m_frame) || TICK !== m_tick || BUSY !== m_busy || DONE !== m_done) begin
        failures++;
        $display("FAIL rand k=%0d got f=%0d t=%b b=%b d=%b exp f=%0d t=%b b=%b d=%b",
                 k, FRAME, TICK, BUSY, DONE, m_frame, m_tick, m_busy, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward_loop();
    test_oneshot_reverse();
    test_pause_resume();
    test_step_idle();
    test_clr_reset();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
